// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two result producers (ALU, MEM) and the
// register-file arbiter. The master side drives requests and hold; the slave
// side is the arbiter.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                 hold;

    logic                 a_req;
    logic [ADDR_W-1:0]    a_addr;
    logic [DATA_W-1:0]    a_data;
    logic                 a_rdy;

    logic                 m_req;
    logic [ADDR_W-1:0]    m_addr;
    logic [DATA_W-1:0]    m_data;
    logic                 m_rdy;

    logic                 we;
    logic [ADDR_W-1:0]    dst_addr;
    logic [DATA_W-1:0]    dst;
    logic [2**ADDR_W-1:0] pend_mask;

    modport master (
        output hold,
        output a_req, a_addr, a_data,
        input  a_rdy,
        output m_req, m_addr, m_data,
        input  m_rdy,
        input  we, dst_addr, dst, pend_mask
    );

    modport slave (
        input  hold,
        input  a_req, a_addr, a_data,
        output a_rdy,
        input  m_req, m_addr, m_data,
        output m_rdy,
        output we, dst_addr, dst, pend_mask
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter. One holding slot per requester (ALU, MEM);
// a single write per cycle is issued from the slots. Same-address writes go
// out in arrival order; otherwise ALU wins unless MEM has lost STARVE_MAX
// arbitrations in a row. A per-register pending mask tracks slot contents.
module rf_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int NREG   = 2**ADDR_W;
    localparam int WAIT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t             a_slot_q, a_slot_d;
    slot_t             m_slot_q, m_slot_d;
    logic              m_older_q, m_older_d;   // 1: MEM slot arrived first
    logic [WAIT_W-1:0] m_wait_q, m_wait_d;     // consecutive lost arbitrations

    logic sel_a, sel_m;
    logic a_rdy, m_rdy;
    logic a_load, m_load;

    // Pick at most one slot to write this cycle, purely from registered state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_a = 1'b0;
        sel_m = 1'b0;
        // Reset also suppresses the write so slots being discarded never reach the register file.
        if (!bus.hold && !rst) begin
            if (a_slot_q.valid && m_slot_q.valid) begin
                if (a_slot_q.addr == m_slot_q.addr) begin
                    sel_m = m_older_q;
                    sel_a = !m_older_q;
                end else if (m_wait_q >= WAIT_MAX) begin
                    sel_m = 1'b1;
                end else begin
                    sel_a = 1'b1;
                end
            end else begin
                sel_a = a_slot_q.valid;
                sel_m = m_slot_q.valid;
            end
        end
    end

    // A slot can accept when it is empty or draining this cycle.
    assign a_rdy  = ~a_slot_q.valid | sel_a;
    assign m_rdy  = ~m_slot_q.valid | sel_m;
    assign a_load = bus.a_req & a_rdy;
    assign m_load = bus.m_req & m_rdy;

    // Next slot contents, age order and MEM starvation counter.
    always_comb begin
        a_slot_d  = a_slot_q;
        m_slot_d  = m_slot_q;
        m_older_d = m_older_q;
        m_wait_d  = m_wait_q;

        if (sel_a) a_slot_d.valid = 1'b0;
        if (sel_m) m_slot_d.valid = 1'b0;

        if (a_load) begin
            a_slot_d.valid = 1'b1;
            a_slot_d.addr  = bus.a_addr;
            a_slot_d.data  = bus.a_data;
        end
        if (m_load) begin
            m_slot_d.valid = 1'b1;
            m_slot_d.addr  = bus.m_addr;
            m_slot_d.data  = bus.m_data;
        end

        // Simultaneous loads treat MEM as older; a lone load is younger than whatever stays.
        if (a_load) begin
            m_older_d = 1'b1;
        end else if (m_load) begin
            m_older_d = 1'b0;
        end

        if (!bus.hold) begin
            if (!m_slot_q.valid || sel_m) begin
                m_wait_d = '0;
            end else if (m_wait_q < WAIT_MAX) begin
                m_wait_d = m_wait_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset; reset discards both slots.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            a_slot_q  <= '0;
            m_slot_q  <= '0;
            m_older_q <= 1'b0;
            m_wait_q  <= '0;
        end else begin
            a_slot_q  <= a_slot_d;
            m_slot_q  <= m_slot_d;
            m_older_q <= m_older_d;
            m_wait_q  <= m_wait_d;
        end
    end

    // Write port and pending scoreboard, derived from slot state.
    always_comb begin
        bus.we        = sel_a | sel_m;
        bus.dst_addr  = '0;
        bus.dst       = '0;
        bus.pend_mask = '0;
        if (sel_a) begin
            bus.dst_addr = a_slot_q.addr;
            bus.dst      = a_slot_q.data;
        end else if (sel_m) begin
            bus.dst_addr = m_slot_q.addr;
            bus.dst      = m_slot_q.data;
        end
        for (int i = 0; i < NREG; i++) begin
            bus.pend_mask[i] = (a_slot_q.valid && a_slot_q.addr == ADDR_W'(i)) ||
                               (m_slot_q.valid && m_slot_q.addr == ADDR_W'(i));
        end
    end

    assign bus.a_rdy = a_rdy;
    assign bus.m_rdy = m_rdy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset state, single write, conflicts,
// same-address ordering, MEM starvation, hold and mid-flight reset.
module tb_rf_wb_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [DATA_W-1:0] rf [2**ADDR_W];

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register-file model fed by the write port.
    always @(posedge clk) begin
        if (bus.we) begin
            rf[bus.dst_addr] <= bus.dst;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic [3:0] addr,
                        input logic [15:0] data);
        check({tag, ".we"}, 32'(bus.we), 32'(we));
        check({tag, ".dst_addr"}, 32'(bus.dst_addr), 32'(addr));
        check({tag, ".dst"}, 32'(bus.dst), 32'(data));
    endtask

    task automatic rdy(input string tag, input logic a, input logic m);
        check({tag, ".a_rdy"}, 32'(bus.a_rdy), 32'(a));
        check({tag, ".m_rdy"}, 32'(bus.m_rdy), 32'(m));
    endtask

    task automatic drive_a(input logic req, input logic [3:0] addr, input logic [15:0] data);
        bus.a_req  = req;
        bus.a_addr = addr;
        bus.a_data = data;
    endtask

    task automatic drive_m(input logic req, input logic [3:0] addr, input logic [15:0] data);
        bus.m_req  = req;
        bus.m_addr = addr;
        bus.m_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rf[i] = '0;
        bus.hold = 1'b0;
        drive_a(1'b0, 4'h0, 16'h0);
        drive_m(1'b0, 4'h0, 16'h0);

        // Reset state
        tick();
        tick();
        port("reset", 1'b0, 4'h0, 16'h0000);
        check("reset.pend", 32'(bus.pend_mask), 32'h0000);
        rdy("reset", 1'b1, 1'b1);
        rst = 1'b0;
        tick();

        // Single ALU write, one-cycle latency
        drive_a(1'b1, 4'h3, 16'h1234);
        tick();
        drive_a(1'b0, 4'h0, 16'h0);
        #1;
        port("single.n1", 1'b1, 4'h3, 16'h1234);
        check("single.pend", 32'(bus.pend_mask), 32'h0008);
        tick();
        port("single.n2", 1'b0, 4'h0, 16'h0000);
        check("single.pend2", 32'(bus.pend_mask), 32'h0000);

        // Different-address conflict: ALU first, MEM stalls one cycle
        drive_a(1'b1, 4'h1, 16'hAAAA);
        drive_m(1'b1, 4'h2, 16'hBBBB);
        tick();
        drive_a(1'b0, 4'h0, 16'h0);
        drive_m(1'b0, 4'h0, 16'h0);
        #1;
        port("conf.c1", 1'b1, 4'h1, 16'hAAAA);
        rdy("conf.c1", 1'b1, 1'b0);
        check("conf.pend", 32'(bus.pend_mask), 32'h0006);
        tick();
        port("conf.c2", 1'b1, 4'h2, 16'hBBBB);
        rdy("conf.c2", 1'b1, 1'b1);
        tick();
        port("conf.c3", 1'b0, 4'h0, 16'h0000);

        // Same-address ordering: MEM (older) then ALU
        drive_m(1'b1, 4'h5, 16'h0001);
        drive_a(1'b1, 4'h5, 16'h0002);
        tick();
        drive_a(1'b0, 4'h0, 16'h0);
        drive_m(1'b0, 4'h0, 16'h0);
        #1;
        port("order.c1", 1'b1, 4'h5, 16'h0001);
        rdy("order.c1", 1'b0, 1'b1);
        check("order.pend", 32'(bus.pend_mask), 32'h0020);
        tick();
        port("order.c2", 1'b1, 4'h5, 16'h0002);
        tick();
        port("order.c3", 1'b0, 4'h0, 16'h0000);
        check("order.rf5", 32'(rf[5]), 32'h0002);

        // Starvation: ALU streams on addr 1, MEM waits on addr 7
        drive_a(1'b1, 4'h1, 16'h0100);
        drive_m(1'b1, 4'h7, 16'h7777);
        tick();
        drive_m(1'b0, 4'h0, 16'h0);
        drive_a(1'b1, 4'h1, 16'h0101);
        #1;
        port("starve.c1", 1'b1, 4'h1, 16'h0100);
        rdy("starve.c1", 1'b1, 1'b0);
        check("starve.pend", 32'(bus.pend_mask), 32'h0082);
        tick();
        drive_a(1'b1, 4'h1, 16'h0102);
        #1;
        port("starve.c2", 1'b1, 4'h1, 16'h0101);
        tick();
        drive_a(1'b1, 4'h1, 16'h0103);
        #1;
        port("starve.c3", 1'b1, 4'h1, 16'h0102);
        tick();
        drive_a(1'b1, 4'h1, 16'h0104);
        #1;
        port("starve.c4", 1'b1, 4'h7, 16'h7777);
        rdy("starve.c4", 1'b0, 1'b1);
        tick();
        port("starve.c5", 1'b1, 4'h1, 16'h0103);
        rdy("starve.c5", 1'b1, 1'b1);
        check("starve.pend5", 32'(bus.pend_mask), 32'h0002);
        tick();
        drive_a(1'b0, 4'h0, 16'h0);
        #1;
        port("starve.c6", 1'b1, 4'h1, 16'h0104);
        tick();
        port("starve.c7", 1'b0, 4'h0, 16'h0000);

        // Hold: both slots parked for 5 cycles, then drain in order
        bus.hold = 1'b1;
        drive_a(1'b1, 4'h2, 16'h2222);
        drive_m(1'b1, 4'h9, 16'h9999);
        tick();
        drive_a(1'b0, 4'h0, 16'h0);
        drive_m(1'b0, 4'h0, 16'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            port("hold", 1'b0, 4'h0, 16'h0000);
            rdy("hold", 1'b0, 1'b0);
            check("hold.pend", 32'(bus.pend_mask), 32'h0204);
            tick();
        end
        bus.hold = 1'b0;
        #1;
        port("hold.d1", 1'b1, 4'h2, 16'h2222);
        tick();
        port("hold.d2", 1'b1, 4'h9, 16'h9999);
        tick();
        port("hold.d3", 1'b0, 4'h0, 16'h0000);

        // Reset mid-flight discards both slots and ignores requests
        bus.hold = 1'b1;
        drive_a(1'b1, 4'h4, 16'h4444);
        drive_m(1'b1, 4'h6, 16'h6666);
        tick();
        drive_m(1'b0, 4'h0, 16'h0);
        check("rstmid.pend0", 32'(bus.pend_mask), 32'h0050);
        rst = 1'b1;
        bus.hold = 1'b0;
        drive_a(1'b1, 4'hF, 16'hFFFF);
        #1;
        check("rstmid.we_in_rst", 32'(bus.we), 32'h0);
        tick();
        rst = 1'b0;
        drive_a(1'b0, 4'h0, 16'h0);
        #1;
        port("rstmid.c1", 1'b0, 4'h0, 16'h0000);
        check("rstmid.pend", 32'(bus.pend_mask), 32'h0000);
        rdy("rstmid.c1", 1'b1, 1'b1);
        tick();
        port("rstmid.c2", 1'b0, 4'h0, 16'h0000);
        check("rstmid.rf4", 32'(rf[4]), 32'h0000);
        check("rstmid.rf6", 32'(rf[6]), 32'h0000);
        check("rstmid.rf15", 32'(rf[15]), 32'h0000);

        // Whole-run bookkeeping: no write dropped or duplicated
        check("final.rf1", 32'(rf[1]), 32'h0104);
        check("final.rf2", 32'(rf[2]), 32'h2222);
        check("final.rf3", 32'(rf[3]), 32'h1234);
        check("final.rf7", 32'(rf[7]), 32'h7777);
        check("final.rf9", 32'(rf[9]), 32'h9999);
        check("final.writes", 32'(n_writes), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
